dl_sched: RTL

DL_SCHED -- requirements
Module: dl_sched

---
 rtl/dl_sched.sv | 118 +++++++++++
 1 files changed

// File: rtl/dl_sched.sv
// Download scheduler: turns the byte-serial download stream into ROM write
// handshakes, DIP/mod register loads and a held game-core reset.
module dl_sched #(
    parameter int ROM_AW      = 16,
    parameter int HOLD_CYCLES = 1024
) (
    input  logic              clk_sys,
    input  logic              reset,
    input  logic              ioctl_download,
    input  logic [7:0]        ioctl_index,
    input  logic              ioctl_wr,
    input  logic [24:0]       ioctl_addr,
    input  logic [7:0]        ioctl_dout,
    output logic              ioctl_wait,
    output logic              rom_wr,
    output logic [ROM_AW-1:0] rom_addr,
    output logic [7:0]        rom_data,
    input  logic              rom_ack,
    output logic [7:0]        mod,
    output logic [63:0]       dip,
    output logic              core_reset
);

    typedef enum logic [1:0] {RUN, IDLE_DL, ROM_WR, HOLD} state_t;

    localparam logic [15:0] HOLD_LOAD = 16'(HOLD_CYCLES - 1);

    state_t      state;
    logic [15:0] hold_cnt;
    logic        dl_q;
    logic        end_pending;
    logic        rom_sel;
    logic        rom_start;

    assign rom_sel   = (ioctl_index == 8'd0);
    assign rom_start = ioctl_download & ~dl_q & rom_sel;

    // Side-channel registers load in every state and never stall the source.
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            mod <= 8'd0;
            dip <= 64'd0;
        end else if (ioctl_wr) begin
            if (ioctl_index == 8'd1)
                mod <= ioctl_dout;
            if (ioctl_index == 8'd254 && ioctl_addr[24:3] == 22'd0)
                dip[{ioctl_addr[2:0], 3'b000} +: 8] <= ioctl_dout;
        end
    end

    // dl_q samples the download line even in reset so a session already
    // running at reset release does not look like a fresh rising edge.
    always_ff @(posedge clk_sys) begin
        dl_q <= ioctl_download;
        if (reset) begin
            state       <= HOLD;
            hold_cnt    <= HOLD_LOAD;
            core_reset  <= 1'b1;
            rom_wr      <= 1'b0;
            ioctl_wait  <= 1'b0;
            rom_addr    <= '0;
            rom_data    <= 8'd0;
            end_pending <= 1'b0;
        end else begin
            case (state)
                RUN: begin
                    if (rom_start) begin
                        state      <= IDLE_DL;
                        core_reset <= 1'b1;
                    end
                end
                IDLE_DL: begin
                    if (!ioctl_download) begin
                        state    <= HOLD;
                        hold_cnt <= HOLD_LOAD;
                    end else if (ioctl_wr && rom_sel) begin
                        rom_addr    <= ioctl_addr[ROM_AW-1:0];
                        rom_data    <= ioctl_dout;
                        rom_wr      <= 1'b1;
                        ioctl_wait  <= 1'b1;
                        end_pending <= 1'b0;
                        state       <= ROM_WR;
                    end
                end
                ROM_WR: begin
                    // Remember a session end seen while the write is still pending.
                    if (!ioctl_download)
                        end_pending <= 1'b1;
                    if (rom_ack) begin
                        rom_wr     <= 1'b0;
                        ioctl_wait <= 1'b0;
                        if (end_pending || !ioctl_download) begin
                            state    <= HOLD;
                            hold_cnt <= HOLD_LOAD;
                        end else begin
                            state <= IDLE_DL;
                        end
                    end
                end
                HOLD: begin
                    if (rom_start) begin
                        state <= IDLE_DL;
                    end else if (hold_cnt == 16'd0) begin
                        state      <= RUN;
                        core_reset <= 1'b0;
                    end else begin
                        hold_cnt <= hold_cnt - 16'd1;
                    end
                end
                default: begin
                    state    <= HOLD;
                    hold_cnt <= HOLD_LOAD;
                end
            endcase
        end
    end

endmodule
